// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient}.
// Define SIGNED_DIV_EN to honour signed_div_i (sign pre/post correction); otherwise every operation is unsigned.
//
//   state   | meaning
//   FREE    | idle, waiting for a launch
//   BY_ZERO | divisor was zero, result forced to 0
//   ON      | iterating, one quotient bit per cycle
//   END     | result valid, held until start_i drops
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, dvd_q, dvs_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               launch, iterate;
    logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix;
    logic [WIDTH:0]     partial, diff;
    logic               fits;
    logic [2*WIDTH-1:0] result_d;
    logic               ready_d;

`ifdef SIGNED_DIV_EN
    logic neg_a, neg_b, neg_q_q, neg_r_q;

    always_comb begin
        neg_a   = signed_div_i & opdata1_i[WIDTH-1];
        neg_b   = signed_div_i & opdata2_i[WIDTH-1];
        abs_a   = neg_a ? -opdata1_i : opdata1_i;
        abs_b   = neg_b ? -opdata2_i : opdata2_i;
        quo_fix = neg_q_q ? -dvd_q : dvd_q;
        rem_fix = neg_r_q ? -rem_q : rem_q;
    end

    // Remainder follows the dividend sign; quotient is negative when the signs differ.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (launch) begin
            neg_q_q <= neg_a ^ neg_b;
            neg_r_q <= neg_a;
        end
    end
`else
    logic unused_signed_div;
    assign unused_signed_div = signed_div_i;
    assign abs_a   = opdata1_i;
    assign abs_b   = opdata2_i;
    assign quo_fix = dvd_q;
    assign rem_fix = rem_q;
`endif

    // Invariant rem_q < dvs_q keeps diff below 2^WIDTH whenever it does not borrow.
    assign partial = {rem_q, dvd_q[WIDTH-1]};
    assign diff    = partial - {1'b0, dvs_q};
    assign fits    = ~diff[WIDTH];

    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        iterate  = 1'b0;
        result_d = result_o;
        ready_d  = ready_o;
        case (state_q)
            FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    launch  = 1'b1;
                    state_d = (opdata2_i == '0) ? BY_ZERO : ON;
                end
            end
            BY_ZERO: begin
                result_d = '0;
                ready_d  = 1'b1;
                state_d  = END;
            end
            ON: begin
                if (annul_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    state_d  = FREE;
                end else if (cnt_q == '0) begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                    state_d  = END;
                end else begin
                    iterate = 1'b1;
                end
            end
            END: begin
                if (!start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    state_d  = FREE;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = 1'b0;
                state_d  = FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FREE;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_o <= result_d;
            ready_o  <= ready_d;
            if (launch) begin
                dvd_q <= abs_a;
                dvs_q <= abs_b;
                rem_q <= '0;
                cnt_q <= CNT_W'(WIDTH);
            end else if (iterate) begin
                rem_q <= fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
                dvd_q <= {dvd_q[WIDTH-2:0], fits};
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: transaction-level timing/arithmetic model checked every cycle,
// plus hand-computed result and latency literals per vector.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        sg;
    logic [31:0] op1, op2;
    logic        start, annul;
    logic [63:0] result_o;
    logic        ready_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (sg),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        logic   use_sgn;
`ifdef SIGNED_DIV_EN
        use_sgn = sgn;
`else
        use_sgn = 1'b0;
`endif
        if (b == 32'h0) return 64'h0;
        if (use_sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Transaction model: an accepted request completes a fixed number of edges later unless flushed.
    logic        m_pending = 1'b0, m_ready = 1'b0, m_zero = 1'b0;
    logic [63:0] m_result = 64'h0, m_value = 64'h0;
    int          m_left = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_pending <= 1'b0;
            m_ready   <= 1'b0;
            m_result  <= 64'h0;
        end else if (m_ready) begin
            if (!start) begin
                m_ready  <= 1'b0;
                m_result <= 64'h0;
            end
        end else if (m_pending) begin
            if (annul && !m_zero) begin
                m_pending <= 1'b0;
            end else if (m_left == 1) begin
                m_pending <= 1'b0;
                m_ready   <= 1'b1;
                m_result  <= m_value;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (start && !annul) begin
            m_pending <= 1'b1;
            m_zero    <= (op2 == 32'h0);
            m_left    <= (op2 == 32'h0) ? 1 : 33;
            m_value   <= ref_div(op1, op2, sg);
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            n_vec++;
            if ({ready_o, result_o} !== {m_ready, m_result}) begin
                n_err++;
                $display("FAIL model cycle %0d: got ready=%b result=%h expected ready=%b result=%h",
                         cyc, ready_o, result_o, m_ready, m_result);
            end
        end
    end

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] es;
        logic [63:0] eu;
        int          lat;
    } vec_t;

    vec_t tbl [11] = '{
        '{32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, 64'h00000002_0000000E, 33},
        '{32'hFFFFFFF9,   32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFD, 64'h00000001_7FFFFFFC, 33},
        '{32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000, 64'h80000000_00000000, 33},
        '{32'd7,          32'hFFFFFFFE,   1'b1, 64'h00000001_FFFFFFFD, 64'h00000007_00000000, 33},
        '{32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 64'hFFFFFFFF_00000003, 64'hFFFFFFF9_00000000, 33},
        '{32'hFFFFFFFF,   32'd1,          1'b0, 64'h00000000_FFFFFFFF, 64'h00000000_FFFFFFFF, 33},
        '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 64'h00000000_00000001, 64'h00000000_00000001, 33},
        '{32'd5,          32'd9,          1'b0, 64'h00000005_00000000, 64'h00000005_00000000, 33},
        '{32'h80000000,   32'd3,          1'b0, 64'h00000002_2AAAAAAA, 64'h00000002_2AAAAAAA, 33},
        '{32'h12345678,   32'd0,          1'b0, 64'h0,                 64'h0,                 1},
        '{32'hFFFFFFFB,   32'd0,          1'b1, 64'h0,                 64'h0,                 1}
    };

    task automatic run_vec(input vec_t v);
        int          lat;
        logic [63:0] exp;
`ifdef SIGNED_DIV_EN
        exp = v.es;
`else
        exp = v.eu;
`endif
        @(posedge clk); #1;
        op1 = v.a; op2 = v.b; sg = v.sgn; start = 1'b1;
        @(posedge clk); #1;
        op1 = ~v.a; op2 = 32'h1; sg = ~v.sgn;
        lat = 99;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (ready_o === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("latency", 65'(lat), 65'(v.lat));
        check("result", {1'b0, result_o}, {1'b0, exp});
        repeat (2) @(posedge clk);
        #1;
        check("held", {ready_o, result_o}, {1'b1, exp});
        start = 1'b0;
        @(posedge clk); #1;
        check("drop", {ready_o, result_o}, 65'h0);
    endtask

    task automatic quiet(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            check(name, {64'h0, ready_o}, 65'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; annul = 1'b0; sg = 1'b0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", {ready_o, result_o}, 65'h0);
        rst = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Flush mid-iteration, then a fresh operation must still finish on time.
        @(posedge clk); #1;
        op1 = 32'd1000; op2 = 32'd3; sg = 1'b0; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        check("annul", {ready_o, result_o}, 65'h0);
        quiet("annul_quiet", 40);
        run_vec('{32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 64'h00000000_00000003, 33});

        // Reset mid-iteration must leave no stale completion.
        @(posedge clk); #1;
        op1 = 32'd50; op2 = 32'd5; sg = 1'b0; start = 1'b1;
        @(posedge clk);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_reset", {ready_o, result_o}, 65'h0);
        quiet("reset_quiet", 40);
        run_vec('{32'd50, 32'd5, 1'b0, 64'h00000000_0000000A, 64'h00000000_0000000A, 33});

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving the DIV/DIVU instructions of the NCUT_MiniSys pipeline. It sits directly downstream of the EX stage: EX launches an operation, stalls the pipeline while the unit iterates, then consumes the {remainder, quotient} pair for writeback to HI/LO. The datapath is a radix-2 restoring shift-subtract, one quotient bit per cycle, with sign pre- and post-correction for signed operation.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at launch only.
- opdata1_i  in  WIDTH  dividend; sampled at launch only.
- opdata2_i  in  WIDTH  divisor; sampled at launch only.
- start_i  in  1  request; held high by EX until the result is consumed.
- annul_i  in  1  cancel request (branch flush or exception); aborts any in-progress division.
- result_o  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; valid only while ready_o=1, else 0.
- ready_o  out  1  result valid.

## Operation
- States: FREE, BY_ZERO, ON, END. Reset → FREE, cnt=0, result_o=0, ready_o=0.
- FREE: start_i=1 and annul_i=0 → launch: if opdata2_i==0 → BY_ZERO, else latch operands (absolute values when signed and sign bit set), record signs, clear partial remainder, cnt=0 → ON. Otherwise stay FREE, ready_o=0, result_o=0.
- BY_ZERO: next edge → END with result_o=0 (quotient 0, remainder 0).
- ON: annul_i=1 → FREE immediately, no result. Otherwise cnt<WIDTH: shift {rem,dividend} left 1; if rem≥divisor subtract and set quotient bit 1, else 0; cnt+1. cnt==WIDTH: apply sign correction, → END, ready_o=1.
- Sign rules (signed mode): quotient negated if dividend sign ≠ divisor sign; remainder takes dividend sign. 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 (two's-complement wrap, no trap).
- END: hold result_o, ready_o=1 while start_i=1. start_i=0 → FREE, result_o=0, ready_o=0 on that edge. annul_i in END is ignored; EX drops start_i.
- Operand changes after launch have no effect.
- rst=1 takes priority over every state at any cycle.

## Timing
- Launch edge N (start_i=1 in FREE). Normal: iterations on edges N+1..N+WIDTH, correction on edge N+WIDTH+1; ready_o=1 from after edge N+33 (WIDTH=32).
- Divide by zero: BY_ZERO after N, END after N+1; ready_o=1 from after edge N+1.
- ready_o registered; deasserts one edge after start_i falls. Back-to-back: new launch no earlier than the edge after returning to FREE.
- Annul in ON: FREE after the same edge; ready_o never asserts for that operation.

## Configuration
- SIGNED_DIV_EN defined: signed_div_i honoured, sign pre/post correction logic present.
- SIGNED_DIV_EN undefined: signed_div_i ignored, every operation unsigned, correction logic removed; latency unchanged.

## Test plan
- Unsigned 100/7, launch edge N → ready_o=1 after edge N+33, result_o={0x00000002, 0x0000000E}; start_i drop → ready_o=0, result_o=0 next edge.
- Signed 0xFFFFFFF9 (−7) / 2 → {0xFFFFFFFF, 0xFFFFFFFD}; without SIGNED_DIV_EN same operands → {0x00000001, 0x7FFFFFFC}.
- Signed 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}, no hang.
- Divisor 0 (either mode) → ready_o=1 after edge N+1, result_o=0.
- annul_i pulsed 10 cycles after launch → FREE next edge, ready_o stays 0 for ≥40 cycles; fresh 9/3 launch then yields {0, 3} on time.
- rst=1 for one cycle mid-ON (cycle 15) → FREE, ready_o=0, result_o=0 after that edge; no stale completion.
